// File: rtl/branch_predictor_if.sv
// Fetch/resolve/statistics bundle between the pipeline and the branch predictor.
// The slave modport is the predictor side; the master modport is the pipeline side.
interface branch_predictor_if #(
    parameter int STAT_W = 16
);
    logic              lookup_valid_i;
    logic              stall_i;
    logic [31:0]       fetch_pc_i;
    logic              hit_o;
    logic              pred_taken_o;
    logic [31:0]       pred_pc_o;
    logic              upd_valid_i;
    logic [31:0]       upd_pc_i;
    logic              upd_is_jump_i;
    logic              upd_taken_i;
    logic [31:0]       upd_target_i;
    logic              upd_pred_taken_i;
    logic [31:0]       upd_pred_pc_i;
    logic              mispredict_o;
    logic [31:0]       redirect_pc_o;
    logic              flush_i;
    logic              clear_stats_i;
    logic [STAT_W-1:0] lookup_cnt_o;
    logic [STAT_W-1:0] hit_cnt_o;
    logic [STAT_W-1:0] br_cnt_o;
    logic [STAT_W-1:0] mispred_cnt_o;

    modport slave (
        input  lookup_valid_i, stall_i, fetch_pc_i,
        input  upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i, upd_target_i,
        input  upd_pred_taken_i, upd_pred_pc_i, flush_i, clear_stats_i,
        output hit_o, pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o,
        output lookup_cnt_o, hit_cnt_o, br_cnt_o, mispred_cnt_o
    );

    modport master (
        output lookup_valid_i, stall_i, fetch_pc_i,
        output upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i, upd_target_i,
        output upd_pred_taken_i, upd_pred_pc_i, flush_i, clear_stats_i,
        input  hit_o, pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o,
        input  lookup_cnt_o, hit_cnt_o, br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, looked up in IF and
// trained in ID, plus saturating hit/branch/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    branch_predictor_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] is_jump_q, is_jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];

    logic [STAT_W-1:0] lookup_cnt_q, lookup_cnt_d, hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx_s, upd_idx_s;
    logic [TAG_W-1:0] lk_tag_s, upd_tag_s;
    logic             hit_s, pred_taken_s, upd_hit_s, mispredict_s, lk_count_s;
    logic [31:0]      pred_pc_s, redirect_pc_s;
    logic             unused_pred_taken;

    // The PC compare decides mispredicts, so the carried taken bit is informational only.
    assign unused_pred_taken = bus.upd_pred_taken_i;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        if (en && (v != {STAT_W{1'b1}})) begin
            return v + STAT_ONE;
        end else begin
            return v;
        end
    endfunction

    // Lookup and resolution: purely combinational on registered table state.
    always_comb begin
        lk_idx_s      = bus.fetch_pc_i[IDX_W+1:2];
        lk_tag_s      = bus.fetch_pc_i[31:IDX_W+2];
        upd_idx_s     = bus.upd_pc_i[IDX_W+1:2];
        upd_tag_s     = bus.upd_pc_i[31:IDX_W+2];
        hit_s         = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        pred_taken_s  = hit_s && (is_jump_q[lk_idx_s] || cnt_q[lk_idx_s][CNT_W-1]);
        pred_pc_s     = pred_taken_s ? target_q[lk_idx_s] : bus.fetch_pc_i + 32'd4;
        upd_hit_s     = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
        redirect_pc_s = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + 32'd4;
        mispredict_s  = bus.upd_valid_i && (redirect_pc_s != bus.upd_pred_pc_i);
        lk_count_s    = bus.lookup_valid_i && !bus.stall_i;
    end

    assign bus.hit_o         = hit_s;
    assign bus.pred_taken_o  = pred_taken_s;
    assign bus.pred_pc_o     = pred_pc_s;
    assign bus.mispredict_o  = mispredict_s;
    assign bus.redirect_pc_o = redirect_pc_s;
    assign bus.lookup_cnt_o  = lookup_cnt_q;
    assign bus.hit_cnt_o     = hit_cnt_q;
    assign bus.br_cnt_o      = br_cnt_q;
    assign bus.mispred_cnt_o = mispred_cnt_q;

    // Table next state: flush beats training; hits train in place, taken misses allocate.
    always_comb begin
        valid_d   = valid_q;
        is_jump_d = is_jump_q;
        tag_d     = tag_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        if (bus.flush_i) begin
            valid_d = '0;
        end else if (bus.upd_valid_i && upd_hit_s) begin
            is_jump_d[upd_idx_s] = bus.upd_is_jump_i;
            target_d[upd_idx_s]  = bus.upd_taken_i ? bus.upd_target_i : target_q[upd_idx_s];
            if (bus.upd_is_jump_i) begin
                cnt_d[upd_idx_s] = CNT_MAX;
            end else if (bus.upd_taken_i) begin
                cnt_d[upd_idx_s] = (cnt_q[upd_idx_s] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx_s] + CNT_ONE;
            end else begin
                cnt_d[upd_idx_s] = (cnt_q[upd_idx_s] == '0) ? '0 : cnt_q[upd_idx_s] - CNT_ONE;
            end
        end else if (bus.upd_valid_i && bus.upd_taken_i) begin
            valid_d[upd_idx_s]   = 1'b1;
            tag_d[upd_idx_s]     = upd_tag_s;
            target_d[upd_idx_s]  = bus.upd_target_i;
            is_jump_d[upd_idx_s] = bus.upd_is_jump_i;
            cnt_d[upd_idx_s]     = bus.upd_is_jump_i ? CNT_MAX : CNT_WT;
        end else begin
            valid_d = valid_q;
        end
    end

    // Statistics next state: clear wins over any increment.
    always_comb begin
        if (bus.clear_stats_i) begin
            lookup_cnt_d  = '0;
            hit_cnt_d     = '0;
            br_cnt_d      = '0;
            mispred_cnt_d = '0;
        end else begin
            lookup_cnt_d  = sat_inc(lookup_cnt_q, lk_count_s);
            hit_cnt_d     = sat_inc(hit_cnt_q, lk_count_s && hit_s);
            br_cnt_d      = sat_inc(br_cnt_q, bus.upd_valid_i);
            mispred_cnt_d = sat_inc(mispred_cnt_q, mispredict_s);
        end
    end

    // Valid bits, counters and statistics: asynchronously reset state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q       <= '0;
            lookup_cnt_q  <= '0;
            hit_cnt_q     <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
            lookup_cnt_q  <= lookup_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk_i) begin
        tag_q     <= tag_d;
        target_q  <= target_d;
        is_jump_q <= is_jump_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// corner sequences, then random traffic against an array-based reference model.
module tb_branch_predictor;
    localparam int STAT_W   = 5;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;

    branch_predictor_if #(.STAT_W(STAT_W)) bus();

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .STAT_W(STAT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one record per table slot, plain integers
    int          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_jmp   [16];
    int          m_cnt   [16];
    int          m_lk, m_hit, m_br, m_mis;

    typedef struct {
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        taken;
        logic        jump;
        logic [31:0] tgt;
        logic [31:0] upd_ppc;
        logic        stall;
        logic [31:0] lk_pc;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_ppc;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc / 64);
    endfunction

    task automatic m_pred(input logic [31:0] pc, output logic hit, output logic tk, output logic [31:0] ppc);
        int s;
        s   = slot(pc);
        hit = (m_valid[s] != 0) && (m_tag[s] == tag_of(pc));
        tk  = hit && ((m_jmp[s] != 0) || (m_cnt[s] >= 2));
        ppc = tk ? m_tgt[s] : pc + 32'd4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_lk = 0; m_hit = 0; m_br = 0; m_mis = 0;
    endtask

    function automatic int sat(input int v, input bit inc);
        return (inc && v < STAT_MAX) ? v + 1 : v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic        h, t;
        logic [31:0] p, redir;
        bit          counted, mis;
        int          s;
        m_pred(bus.fetch_pc_i, h, t, p);
        counted = bus.lookup_valid_i && !bus.stall_i;
        redir   = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + 32'd4;
        mis     = bus.upd_valid_i && (redir != bus.upd_pred_pc_i);
        if (bus.clear_stats_i) begin
            m_lk = 0; m_hit = 0; m_br = 0; m_mis = 0;
        end else begin
            m_lk  = sat(m_lk, counted);
            m_hit = sat(m_hit, counted && h);
            m_br  = sat(m_br, bus.upd_valid_i);
            m_mis = sat(m_mis, mis);
        end
        s = slot(bus.upd_pc_i);
        if (bus.flush_i) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (bus.upd_valid_i && m_valid[s] != 0 && m_tag[s] == tag_of(bus.upd_pc_i)) begin
            if (bus.upd_is_jump_i) m_cnt[s] = 3;
            else if (bus.upd_taken_i) m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
            else m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
            m_jmp[s] = bus.upd_is_jump_i;
            if (bus.upd_taken_i) m_tgt[s] = bus.upd_target_i;
        end else if (bus.upd_valid_i && bus.upd_taken_i) begin
            m_valid[s] = 1;
            m_tag[s]   = tag_of(bus.upd_pc_i);
            m_tgt[s]   = bus.upd_target_i;
            m_jmp[s]   = bus.upd_is_jump_i;
            m_cnt[s]   = bus.upd_is_jump_i ? 3 : 2;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lookup_valid_i = 1'b0; bus.stall_i = 1'b0; bus.fetch_pc_i = 32'h0;
        bus.upd_valid_i = 1'b0; bus.upd_pc_i = 32'h0; bus.upd_is_jump_i = 1'b0;
        bus.upd_taken_i = 1'b0; bus.upd_target_i = 32'h0; bus.upd_pred_taken_i = 1'b0;
        bus.upd_pred_pc_i = 32'h0; bus.flush_i = 1'b0; bus.clear_stats_i = 1'b0;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic jmp,
                           input logic [31:0] tgt, input logic [31:0] ppc);
        bus.upd_valid_i = v; bus.upd_pc_i = pc; bus.upd_taken_i = tk;
        bus.upd_is_jump_i = jmp; bus.upd_target_i = tgt; bus.upd_pred_pc_i = ppc;
        bus.upd_pred_taken_i = (ppc != pc + 32'd4);
    endtask

    task automatic chk_stats(input string tag, input int lk, input int ht, input int br, input int ms);
        chk({tag, ".lookup_cnt"}, 32'(bus.lookup_cnt_o), 32'(lk));
        chk({tag, ".hit_cnt"}, 32'(bus.hit_cnt_o), 32'(ht));
        chk({tag, ".br_cnt"}, 32'(bus.br_cnt_o), 32'(br));
        chk({tag, ".mispred_cnt"}, 32'(bus.mispred_cnt_o), 32'(ms));
    endtask

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic tk, input logic jmp,
                                input logic [31:0] tgt, input logic [31:0] ppc, input logic st,
                                input logic [31:0] lk, input logic eh, input logic et,
                                input logic [31:0] ep, input logic em, input logic [31:0] er);
        vec_t v;
        v = '{uv, upc, tk, jmp, tgt, ppc, st, lk, eh, et, ep, em, er};
        return v;
    endfunction

    initial begin
        logic        h, t;
        logic [31:0] p, upc, tgt, ppc, lpc;
        logic        jmp, tk;

        // Expected values hand-derived from the predictor rules (CNT_W=2, 16 entries)
        vecs[0]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b0, 1'b0, 32'h44,  1'b0, 32'h4);
        vecs[1]  = mk(1'b1, 32'h40,  1'b1, 1'b0, 32'h80,  32'h44,  1'b0, 32'h40,  1'b0, 1'b0, 32'h44,  1'b1, 32'h80);
        vecs[2]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b0, 32'h4);
        vecs[3]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h80,  32'h80,  1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b1, 32'h44);
        vecs[4]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h80,  32'h44,  1'b0, 32'h40,  1'b1, 1'b0, 32'h44,  1'b0, 32'h44);
        vecs[5]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h80,  32'h44,  1'b0, 32'h40,  1'b1, 1'b0, 32'h44,  1'b0, 32'h44);
        vecs[6]  = mk(1'b1, 32'h40,  1'b1, 1'b0, 32'h80,  32'h44,  1'b0, 32'h40,  1'b1, 1'b0, 32'h44,  1'b1, 32'h80);
        vecs[7]  = mk(1'b1, 32'h40,  1'b1, 1'b0, 32'h80,  32'h44,  1'b0, 32'h40,  1'b1, 1'b0, 32'h44,  1'b1, 32'h80);
        vecs[8]  = mk(1'b1, 32'h40,  1'b1, 1'b0, 32'h80,  32'h80,  1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b0, 32'h80);
        vecs[9]  = mk(1'b1, 32'h40,  1'b1, 1'b0, 32'h80,  32'h80,  1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b0, 32'h80);
        vecs[10] = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h80,  32'h80,  1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b1, 32'h44);
        vecs[11] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b1, 32'h80,  1'b0, 32'h4);
        vecs[12] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h440, 1'b0, 1'b0, 32'h444, 1'b0, 32'h4);
        vecs[13] = mk(1'b1, 32'h440, 1'b1, 1'b0, 32'h500, 32'h444, 1'b0, 32'h440, 1'b0, 1'b0, 32'h444, 1'b1, 32'h500);
        vecs[14] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h440, 1'b1, 1'b1, 32'h500, 1'b0, 32'h4);
        vecs[15] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b0, 1'b0, 32'h44,  1'b0, 32'h4);
        vecs[16] = mk(1'b1, 32'h60,  1'b1, 1'b1, 32'h200, 32'h64,  1'b0, 32'h60,  1'b0, 1'b0, 32'h64,  1'b1, 32'h200);
        vecs[17] = mk(1'b1, 32'h60,  1'b1, 1'b1, 32'h300, 32'h200, 1'b0, 32'h60,  1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
        vecs[18] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h60,  1'b1, 1'b1, 32'h300, 1'b0, 32'h4);
        vecs[19] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 32'h60,  1'b1, 1'b1, 32'h300, 1'b0, 32'h4);

        idle_inputs();
        model_reset();
        bus.lookup_valid_i = 1'b1;
        bus.fetch_pc_i = 32'h40;
        @(posedge clk_i);
        #1;
        chk("reset.hit", 32'(bus.hit_o), 32'h0);
        chk("reset.taken", 32'(bus.pred_taken_o), 32'h0);
        chk("reset.pred_pc", bus.pred_pc_o, 32'h44);
        chk("reset.mispredict", 32'(bus.mispredict_o), 32'h0);
        chk_stats("reset", 0, 0, 0, 0);
        rst_i = 1'b1;

        // Directed table: lookup results reflect state before this row's update
        for (int i = 0; i < 20; i++) begin
            set_upd(vecs[i].upd_v, vecs[i].upd_pc, vecs[i].taken, vecs[i].jump, vecs[i].tgt, vecs[i].upd_ppc);
            bus.lookup_valid_i = 1'b1;
            bus.stall_i = vecs[i].stall;
            bus.fetch_pc_i = vecs[i].lk_pc;
            #1;
            chk($sformatf("vec%0d.hit", i), 32'(bus.hit_o), 32'(vecs[i].e_hit));
            chk($sformatf("vec%0d.taken", i), 32'(bus.pred_taken_o), 32'(vecs[i].e_taken));
            chk($sformatf("vec%0d.pred_pc", i), bus.pred_pc_o, vecs[i].e_ppc);
            chk($sformatf("vec%0d.mispredict", i), 32'(bus.mispredict_o), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d.redirect", i), bus.redirect_pc_o, vecs[i].e_redir);
            tick();
            if (i == 0) chk_stats("cold", 1, 0, 0, 0);
        end
        chk_stats("table", 19, 13, 12, 8);

        // Clear wins over a counted lookup in the same cycle
        idle_inputs();
        bus.lookup_valid_i = 1'b1;
        bus.fetch_pc_i = 32'h60;
        bus.clear_stats_i = 1'b1;
        tick();
        chk_stats("clear", 0, 0, 0, 0);

        // Flush beats a simultaneous taken update
        idle_inputs();
        set_upd(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h44);
        tick();
        set_upd(1'b1, 32'h60, 1'b1, 1'b0, 32'h300, 32'h300);
        bus.flush_i = 1'b1;
        tick();
        idle_inputs();
        bus.fetch_pc_i = 32'h40;
        #1;
        chk("flush.hit40", 32'(bus.hit_o), 32'h0);
        bus.fetch_pc_i = 32'h60;
        #1;
        chk("flush.hit60", 32'(bus.hit_o), 32'h0);
        chk_stats("flush", 0, 0, 2, 1);

        // Asynchronous reset between edges after training
        set_upd(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h44);
        tick();
        idle_inputs();
        bus.lookup_valid_i = 1'b1;
        bus.fetch_pc_i = 32'h40;
        #1;
        chk("prereset.hit", 32'(bus.hit_o), 32'h1);
        #1;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("areset.hit", 32'(bus.hit_o), 32'h0);
        chk("areset.pred_pc", bus.pred_pc_o, 32'h44);
        chk_stats("areset", 0, 0, 0, 0);
        #1;
        rst_i = 1'b1;
        tick();
        chk("postreset.hit", 32'(bus.hit_o), 32'h0);
        chk_stats("postreset", 1, 0, 0, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            lpc = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2));
            upc = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2));
            jmp = ($urandom_range(0, 7) == 0);
            tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = 32'h0001_0000 | 32'($urandom_range(0, 255) << 2);
            m_pred(upc, h, t, p);
            ppc = ($urandom_range(0, 3) != 0) ? p : tgt;
            set_upd(1'($urandom_range(0, 2) != 0), upc, tk, jmp, tgt, ppc);
            bus.lookup_valid_i = 1'($urandom_range(0, 4) != 0);
            bus.stall_i = ($urandom_range(0, 5) == 0);
            bus.fetch_pc_i = lpc;
            bus.flush_i = ($urandom_range(0, 59) == 0);
            bus.clear_stats_i = ($urandom_range(0, 79) == 0);
            #1;
            m_pred(lpc, h, t, p);
            chk("rnd.hit", 32'(bus.hit_o), 32'(h));
            chk("rnd.taken", 32'(bus.pred_taken_o), 32'(t));
            chk("rnd.pred_pc", bus.pred_pc_o, p);
            chk("rnd.redirect", bus.redirect_pc_o, tk ? tgt : upc + 32'd4);
            chk("rnd.mispredict", 32'(bus.mispredict_o),
                32'(bus.upd_valid_i && ((tk ? tgt : upc + 32'd4) != ppc)));
            tick();
            chk_stats("rnd", m_lk, m_hit, m_br, m_mis);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
